// File: rtl/mod6_sequence_checker.sv
// mod6_sequence_checker
// Registered monitor placed downstream of a modulo-6 counter. Every cycle it
// checks that the counter stepped by +1 (mod 6) when enabled and held when not.
// It counts completed 5 -> 0 wraps and raises a sticky error flag on any illegal
// value or step. All outputs are registered.
//
// Optional build macro:
//   MOD6_CHK_SATURATE_EN - when defined, the wrap counter saturates at its
//                          maximum value. Otherwise it rolls over modulo 2^WRAP_W.
module mod6_sequence_checker #(
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        count,
  input  logic              clear,
  output logic [WRAP_W-1:0] wraps,
  output logic              wrap_pulse,
  output logic              error,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ERROR = 2'b10
  } state_t;

  state_t            state_reg;
  logic [2:0]        c_s_reg;
  logic              e_s_reg;
  logic [WRAP_W-1:0] wraps_reg;
  logic              wrap_pulse_reg;
  logic              error_reg;

  logic [2:0]        exp_cnt;
  logic              count_legal;
  logic              step_ok;
  logic              wrap_hit;
  logic [WRAP_W-1:0] wraps_next;

  // Predict this cycle's count from the previous sample, and classify the new one.
  always_comb begin
    exp_cnt     = c_s_reg;
    if (e_s_reg) begin
      exp_cnt = (c_s_reg == 3'd5) ? 3'd0 : c_s_reg + 3'd1;
    end
    count_legal = (count <= 3'd5);
    step_ok     = count_legal && (count == exp_cnt);
    wrap_hit    = e_s_reg && (c_s_reg == 3'd5) && (count == 3'd0);
  end

  // Incremented wrap count; saturating or rolling over depending on the build.
  always_comb begin
`ifdef MOD6_CHK_SATURATE_EN
    wraps_next = (wraps_reg == {WRAP_W{1'b1}}) ? wraps_reg : wraps_reg + WRAP_W'(1);
`else
    wraps_next = wraps_reg + WRAP_W'(1);
`endif
  end

  // Sample capture plus the IDLE/TRACK/ERROR state machine with its registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      c_s_reg        <= 3'd0;
      e_s_reg        <= 1'b0;
      wraps_reg      <= '0;
      wrap_pulse_reg <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      // The samples are taken in every state, including during a clear,
      // so tracking can resume from a valid reference afterwards.
      c_s_reg <= count;
      e_s_reg <= enable;
      if (clear) begin
        // Clear wins over any wrap or violation seen on the same edge.
        state_reg      <= IDLE;
        wraps_reg      <= '0;
        wrap_pulse_reg <= 1'b0;
        error_reg      <= 1'b0;
      end else begin
        wrap_pulse_reg <= 1'b0;
        case (state_reg)
          IDLE: begin
            // First sample only establishes the reference; no step check.
            if (count_legal) begin
              state_reg <= TRACK;
            end else begin
              state_reg <= ERROR;
              error_reg <= 1'b1;
            end
          end
          TRACK: begin
            if (!step_ok) begin
              state_reg <= ERROR;
              error_reg <= 1'b1;
            end else if (wrap_hit) begin
              wraps_reg      <= wraps_next;
              wrap_pulse_reg <= 1'b1;
            end
          end
          ERROR: begin
            // Sticky: statistics frozen until clear or reset.
            state_reg <= ERROR;
          end
          default: begin
            state_reg <= ERROR;
            error_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign wraps      = wraps_reg;
  assign wrap_pulse = wrap_pulse_reg;
  assign error      = error_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_mod6_sequence_checker.sv
// tb_mod6_sequence_checker
// Drives two checker instances (default wrap width and a 2-bit wrap width)
// with directed and randomized counter traffic and compares every output,
// every cycle, against a behavioural model of the checking rules.
module tb_mod6_sequence_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [2:0] count;

  logic [7:0] wraps8;
  logic       pulse8;
  logic       err8;
  logic [1:0] st8;
  logic [1:0] wraps2;
  logic       pulse2;
  logic       err2;
  logic [1:0] st2;

  always #5 clk = ~clk;

  mod6_sequence_checker #(.WRAP_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .count(count), .clear(clear),
    .wraps(wraps8), .wrap_pulse(pulse8), .error(err8), .state(st8)
  );

  mod6_sequence_checker #(.WRAP_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .enable(enable), .count(count), .clear(clear),
    .wraps(wraps2), .wrap_pulse(pulse2), .error(err2), .state(st2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: previous sample, whether a reference exists, sticky error,
  // and the unbounded number of wraps seen since reset/clear.
  bit m_have;
  bit m_err;
  bit m_pulse;
  int m_total;
  int m_prev_cnt;
  bit m_prev_en;

  int ucnt;   // upstream mod-6 counter modelled by the bench
  int p8;     // observed pulse counts
  int p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_wraps(input int w);
    int lim;
    lim = 1 << w;
`ifdef MOD6_CHK_SATURATE_EN
    return (m_total >= lim) ? lim - 1 : m_total;
`else
    return m_total % lim;
`endif
  endfunction

  function automatic int exp_state();
    if (m_err) return 2;
    if (m_have) return 1;
    return 0;
  endfunction

  // Apply the checking rules to the inputs present at the clock edge.
  task automatic model_edge();
    int pred;
    int c;
    c = int'(count);
    if (!reset) begin
      m_have = 0; m_err = 0; m_pulse = 0; m_total = 0;
      m_prev_cnt = 0; m_prev_en = 0;
    end else begin
      if (clear) begin
        m_have = 0; m_err = 0; m_pulse = 0; m_total = 0;
      end else begin
        m_pulse = 0;
        if (!m_err) begin
          if (!m_have) begin
            m_have = 1;
            if (c > 5) m_err = 1;
          end else begin
            pred = m_prev_en ? (m_prev_cnt + 1) % 6 : m_prev_cnt;
            if (c > 5 || c != pred) begin
              m_err = 1;
            end else if (m_prev_en && m_prev_cnt == 5 && c == 0) begin
              m_total++;
              m_pulse = 1;
            end
          end
        end
      end
      m_prev_cnt = c;
      m_prev_en  = enable;
    end
  endtask

  // One clock cycle: drive, let the edge happen, update model, compare.
  task automatic cycle(input bit rst, input bit clr, input bit en, input int cnt);
    logic [2:0] cv;
    cv     = cnt[2:0];
    reset  = rst;
    clear  = clr;
    enable = en;
    count  = cv;
    @(posedge clk);
    model_edge();
    #1;
    check("wraps8", 32'(wraps8), exp_wraps(8));
    check("pulse8", 32'(pulse8), 32'(m_pulse));
    check("error8", 32'(err8),   32'(m_err));
    check("state8", 32'(st8),    exp_state());
    check("wraps2", 32'(wraps2), exp_wraps(2));
    check("pulse2", 32'(pulse2), 32'(m_pulse));
    check("error2", 32'(err2),   32'(m_err));
    check("state2", 32'(st2),    exp_state());
    if (pulse8) p8++;
    if (pulse2) p2++;
    $display("cyc rst=%0b clr=%0b en=%0b cnt=%0d -> wraps=%0d/%0d pulse=%0b err=%0b st=%0d",
             rst, clr, en, cv, wraps8, wraps2, pulse8, err8, st8);
  endtask

  // Cycle with the bench's upstream counter supplying count.
  task automatic ctr(input bit rst, input bit clr, input bit en);
    cycle(rst, clr, en, ucnt);
    if (!rst) ucnt = 0;
    else if (en) ucnt = (ucnt + 1) % 6;
  endtask

  initial begin
    int r;
    int v;
    reset = 1'b0; clear = 1'b0; enable = 1'b0; count = 3'd0;
    m_have = 0; m_err = 0; m_pulse = 0; m_total = 0;
    m_prev_cnt = 0; m_prev_en = 0;
    ucnt = 0; p8 = 0; p2 = 0;

    // Reset with a nonzero count and enable asserted
    cycle(1'b0, 1'b0, 1'b1, 3);
    check("rst_wraps", 32'(wraps8), 0);
    check("rst_state", 32'(st8), 0);
    ctr(1'b0, 1'b0, 1'b1);

    // Nominal: 13 enabled cycles from 0 -> two wraps
    p8 = 0;
    repeat (13) ctr(1'b1, 1'b0, 1'b1);
    check("nom_wraps", 32'(wraps8), 2);
    check("nom_pulses", 32'(p8), 2);
    check("nom_error", 32'(err8), 0);

    // Hold at 4 for 5 cycles
    repeat (3) ctr(1'b1, 1'b0, 1'b1);
    p8 = 0;
    repeat (5) ctr(1'b1, 1'b0, 1'b0);
    check("hold_state", 32'(st8), 1);
    check("hold_error", 32'(err8), 0);
    check("hold_pulses", 32'(p8), 0);

    // Violation: 2 -> 4 while enabled, then legal wraps must not count
    repeat (4) ctr(1'b1, 1'b0, 1'b1);
    ctr(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 4);
    check("viol_error", 32'(err8), 1);
    check("viol_state", 32'(st8), 2);
    ucnt = 5;
    p8 = 0;
    repeat (12) ctr(1'b1, 1'b0, 1'b1);
    check("viol_wraps_frozen", 32'(wraps8), 3);
    check("viol_no_pulse", 32'(p8), 0);

    // Illegal value 7
    ctr(1'b1, 1'b1, 1'b1);
    repeat (2) ctr(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 7);
    check("val7_error", 32'(err8), 1);

    // Clear on the same edge as a 5 -> 0 wrap
    ctr(1'b1, 1'b1, 1'b1);
    ucnt = 4;
    repeat (2) ctr(1'b1, 1'b0, 1'b1);
    ctr(1'b1, 1'b1, 1'b1);
    check("clr_wraps", 32'(wraps8), 0);
    check("clr_pulse", 32'(pulse8), 0);
    check("clr_error", 32'(err8), 0);
    check("clr_state", 32'(st8), 0);

    // Overflow on the 2-bit instance: four wraps
    ucnt = 1;
    p2 = 0;
    repeat (24) ctr(1'b1, 1'b0, 1'b1);
`ifdef MOD6_CHK_SATURATE_EN
    check("ovf_wraps2", 32'(wraps2), 3);
`else
    check("ovf_wraps2", 32'(wraps2), 0);
`endif
    check("ovf_pulses2", 32'(p2), 4);
    check("ovf_wraps8", 32'(wraps8), 4);

    // Randomized traffic: mostly legal counting, with occasional faults,
    // clears and resets
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        ctr(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end else if (r < 5) begin
        ctr(1'b1, 1'b1, 1'($urandom_range(0, 1)));
      end else if (r < 9) begin
        v = int'($urandom_range(0, 7));
        cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), v);
        ucnt = (v < 6) ? v : 0;
      end else begin
        ctr(1'b1, 1'b0, $urandom_range(0, 3) != 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod6_sequence_checker.md
# mod6_sequence_checker

Registered monitor that sits directly downstream of the modulo-6 counter and consumes its `count` and `enable` signals. It checks every cycle that the counter advances by exactly +1 (mod 6) when enabled and holds otherwise. It counts completed wrap-arounds (5 → 0) and flags a sticky error on any illegal value or step. It is used as an in-design assertion/statistics stage and as a self-checking aid for counter benches.

## Interface
Parameters:
- `WRAP_W`, default 8: width of the wrap counter output.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — synchronous, active-low reset; sampled on rising edge of `clk`.
- `enable`  in  1  — same net that drives the upstream counter's enable.
- `count`  in  3  — upstream counter value.
- `clear`  in  1  — synchronous soft clear of statistics and error.
- `wraps`  out  `WRAP_W`  — number of completed 5 → 0 wraps since reset/clear.
- `wrap_pulse`  out  1  — one-cycle pulse per detected wrap.
- `error`  out  1  — sticky sequence-violation flag.
- `state`  out  2  — FSM state: 00 IDLE, 01 TRACK, 10 ERROR.

## Operation
- Sample registers `c_s[2:0]` and `e_s` capture `count` and `enable` on every edge, in every state.
- Prediction at each edge: `exp = e_s ? (c_s == 5 ? 0 : c_s + 1) : c_s`.
- FSM:
  - IDLE: captures the first sample and performs no check. Goes to TRACK next edge if `count` ≤ 5, else to ERROR.
  - TRACK: if `count` > 5 or `count` ≠ `exp`, go to ERROR and set `error` = 1.
  - TRACK wrap: if `e_s` = 1, `c_s` = 5 and `count` = 0, then `wraps` increments and `wrap_pulse` = 1 for one cycle.
  - ERROR: sticky. `wraps` is frozen and `wrap_pulse` stays 0. Left only via `clear` or `reset`.
- `clear` = 1 (with `reset` = 1): next state IDLE; `wraps` = 0, `error` = 0, `wrap_pulse` = 0. It overrides any wrap or violation detected in the same cycle.
- `reset` = 0 overrides `clear` and everything else.
- Arithmetic: the comparison is 3-bit. Values 6 and 7 on `count` are always illegal outside IDLE's first sample, and that sample also errors if > 5.

## Timing
- Reset values: `wraps` = 0, `wrap_pulse` = 0, `error` = 0, `state` = IDLE (00). `c_s` = 0, `e_s` = 0.
- All outputs are registered; there are no combinational input→output paths.
- Check latency: the counter updates at edge N, the checker compares at edge N+1, and `error`/`wrap_pulse` are visible after edge N+1. This is one cycle after `count` first shows the offending or wrapped value.
- `wrap_pulse` is high for exactly one cycle per wrap, even on consecutive wraps (not possible with mod 6 at one step/cycle, but no merging logic is permitted).
- Reset mid-operation: at the reset edge all state returns to reset values. The first edge after release is IDLE (no check).
- Counter reset observed while tracking: `count` jumping to 0 without a 5 → 0 enabled step is a violation. The upstream counter and checker must share reset.

## Configuration
- `MOD6_CHK_SATURATE_EN`
  - Defined: `wraps` saturates at 2^`WRAP_W` − 1 and holds. `wrap_pulse` still fires on each wrap.
  - Undefined: `wraps` rolls over modulo 2^`WRAP_W` (e.g. `WRAP_W` = 8: 255 → 0).

## Test plan
- Reset: hold `reset` = 0 for 1 cycle with `count` = 3, `enable` = 1 → `wraps` = 0, `wrap_pulse` = 0, `error` = 0, `state` = 00.
- Nominal: real counter reset to 0, `enable` = 1 for 13 cycles → `count` = 1, `wraps` = 2, exactly 2 `wrap_pulse` cycles, each one cycle after `count` = 0, `error` = 0.
- Hold: counter at 4, `enable` = 0 for 5 cycles → `count` stays 4, `error` = 0, no pulse, `state` = 01.
- Violations:
  - Force `count` 2 → 4 with `enable` = 1 → `error` = 1 and `state` = 10 one cycle later; later legal wraps leave `wraps` unchanged.
  - Force `count` = 7 → `error` = 1.
- Clear priority: assert `clear` on the same edge a 5 → 0 wrap is evaluated → `wraps` = 0, `wrap_pulse` = 0, `error` = 0, `state` = 00.
- Overflow, `WRAP_W` = 2, 4 wraps:
  - With `MOD6_CHK_SATURATE_EN`: `wraps` = 3.
  - Without it: `wraps` = 0.
  - Both cases: 4 `wrap_pulse` cycles.
